// File: rtl/mem_arb_pkg.sv
// Shared definitions for the mem8k port arbiter: default widths, FSM states
// and master index constants.
package mem_arb_pkg;

    localparam int AW_DEF = 13;
    localparam int DW_DEF = 16;

    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Two-way request selector. Fixed priority (master 0 wins ties) by default;
// round-robin on ties when ARB_ROUND_ROBIN_EN is defined.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_owner,
    output logic       o_grant,
    output logic       o_valid
);

    assign o_valid = |i_req;

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        o_grant = M_CPU;
        if (i_req == 2'b11) begin
            o_grant = (i_last_owner == M_CPU) ? M_AUX : M_CPU;
        end else if (i_req[1]) begin
            o_grant = M_AUX;
        end
    end
`else
    logic w_unused_last_owner;
    assign w_unused_last_owner = i_last_owner;

    always_comb begin
        o_grant = M_CPU;
        if (!i_req[0] && i_req[1]) begin
            o_grant = M_AUX;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the mem8k port between the CPU path (master 0) and the loader path
// (master 1). Tie-break mode selected by ARB_ROUND_ROBIN_EN (see arb_pick).
//
// state | meaning
// IDLE  | waiting for a request; latches the winner's command
// ISSUE | drives address/data and raises the read or write strobe
// WAIT  | holds the strobe until the matching done or the watchdog expires
// RESP  | one-cycle ack (and err) to the owner
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    output logic          m0_err,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic          m1_err,

    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rd_done,
    input  logic          mem_wr_done,

    output logic          busy,
    output logic          owner
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    arb_state_t     r_state;
    logic           r_we;
    logic [AW-1:0]  r_addr;
    logic [DW-1:0]  r_wdata;
    logic [WDW-1:0] r_wdog;
    logic           r_last_owner;

    logic           w_grant;
    logic           w_valid;
    logic           w_done;

    arb_pick u_pick (
        .i_req        ({m1_req, m0_req}),
        .i_last_owner (r_last_owner),
        .o_grant      (w_grant),
        .o_valid      (w_valid)
    );

    // Only the done matching the latched direction completes the access.
    assign w_done = r_we ? mem_wr_done : mem_rd_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wdog       <= '0;
            r_last_owner <= M_AUX;
            m0_rdata     <= '0;
            m0_ack       <= 1'b0;
            m0_err       <= 1'b0;
            m1_rdata     <= '0;
            m1_ack       <= 1'b0;
            m1_err       <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
            owner        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_we         <= (w_grant == M_AUX) ? m1_we    : m0_we;
                        r_addr       <= (w_grant == M_AUX) ? m1_addr  : m0_addr;
                        r_wdata      <= (w_grant == M_AUX) ? m1_wdata : m0_wdata;
                        owner        <= w_grant;
                        r_last_owner <= w_grant;
                        busy         <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_addr  <= r_addr;
                    mem_wdata <= r_wdata;
                    mem_read  <= ~r_we;
                    mem_write <= r_we;
                    r_wdog    <= '0;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    if (w_done) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (owner == M_AUX) begin
                            m1_ack   <= 1'b1;
                            m1_rdata <= r_we ? '0 : mem_rdata;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_rdata <= r_we ? '0 : mem_rdata;
                        end
                        r_state <= RESP;
                    end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
                        // Watchdog expiry: abort with err and zero data.
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        r_wdog    <= r_wdog + 1'b1;
                        if (owner == M_AUX) begin
                            m1_ack   <= 1'b1;
                            m1_err   <= 1'b1;
                            m1_rdata <= '0;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_err   <= 1'b1;
                            m0_rdata <= '0;
                        end
                        r_state <= RESP;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                RESP: begin
                    m0_ack   <= 1'b0;
                    m0_err   <= 1'b0;
                    m0_rdata <= '0;
                    m1_ack   <= 1'b0;
                    m1_err   <= 1'b0;
                    m1_rdata <= '0;
                    busy     <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a timestamp-based model.
module tb_mem_port_arbiter;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [12:0] m0_addr = '0, m1_addr = '0;
    logic [15:0] m0_wdata = '0, m1_wdata = '0;
    logic [15:0] m0_rdata, m1_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        mem_read, mem_write;
    logic [12:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_rd_done = 1'b0, mem_wr_done = 1'b0;
    logic        busy, owner;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(.AW(13), .DW(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rd_done(mem_rd_done), .mem_wr_done(mem_wr_done),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: done appears in strobe cycle number cur_lat (0-based).
    bit          rnd_mem = 1'b0;
    int          dir_lat = 0;
    bit          dir_stray = 1'b0;
    logic [15:0] dir_rdata = '0;
    int          scnt = 0;
    int          cur_lat = 0;

    always @(negedge clk) begin
        if (mem_read || mem_write) begin
            mem_rd_done = mem_read  ? (scnt == cur_lat) : (rnd_mem ? 1'($urandom_range(0, 1)) : dir_stray);
            mem_wr_done = mem_write ? (scnt == cur_lat) : (rnd_mem ? 1'($urandom_range(0, 1)) : dir_stray);
            scnt++;
        end else begin
            scnt = 0;
            if (rnd_mem) cur_lat = ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(0, 3));
            else         cur_lat = dir_lat;
            mem_rd_done = rnd_mem ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_wr_done = rnd_mem ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        mem_rdata = rnd_mem ? 16'($urandom) : dir_rdata;
    end

    // Reference model: one transaction described by its grant edge g and
    // finish edge f; all expected outputs follow from those timestamps.
    int          ecount = 0;
    bit          md_act = 1'b0, md_fin = 1'b0;
    int          md_g = 0, md_f = 0;
    logic        md_owner = 1'b0, md_last = 1'b1, md_we = 1'b0, md_err = 1'b0;
    logic [12:0] md_addr = '0;
    logic [15:0] md_wdata = '0, md_rdata = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            md_act = 1'b0; md_fin = 1'b0; md_owner = 1'b0; md_last = 1'b1;
            md_err = 1'b0; md_rdata = '0;
        end else begin
            ecount++;
            if (md_act && md_fin) begin
                if (ecount == md_f + 1) md_act = 1'b0;
            end else if (md_act) begin
                if (ecount >= md_g + 2) begin
                    if (md_we ? mem_wr_done : mem_rd_done) begin
                        md_fin = 1'b1; md_f = ecount; md_err = 1'b0;
                        md_rdata = md_we ? 16'h0 : mem_rdata;
                    end else if (ecount == md_g + 1 + TO) begin
                        md_fin = 1'b1; md_f = ecount; md_err = 1'b1; md_rdata = 16'h0;
                    end
                end
            end else if (m0_req || m1_req) begin
                logic w;
                if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    w = (md_last == 1'b0);
`else
                    w = 1'b0;
`endif
                end else begin
                    w = m1_req;
                end
                md_owner = w; md_last = w;
                md_we    = w ? m1_we    : m0_we;
                md_addr  = w ? m1_addr  : m0_addr;
                md_wdata = w ? m1_wdata : m0_wdata;
                md_act = 1'b1; md_fin = 1'b0; md_g = ecount;
            end
        end
    end

    always @(negedge clk) begin
        bit es, ea;
        es = md_act && !md_fin && (ecount >= md_g + 1);
        ea = md_act && md_fin;
        chk("busy",      busy,      md_act);
        chk("owner",     owner,     md_owner);
        chk("mem_read",  mem_read,  es && !md_we);
        chk("mem_write", mem_write, es && md_we);
        chk("m0_ack",    m0_ack,    ea && md_owner == 1'b0);
        chk("m1_ack",    m1_ack,    ea && md_owner == 1'b1);
        chk("m0_err",    m0_err,    ea && md_owner == 1'b0 && md_err);
        chk("m1_err",    m1_err,    ea && md_owner == 1'b1 && md_err);
        chk("m0_rdata",  m0_rdata,  (ea && md_owner == 1'b0) ? md_rdata : 16'h0);
        chk("m1_rdata",  m1_rdata,  (ea && md_owner == 1'b1) ? md_rdata : 16'h0);
        if (es) begin
            chk("mem_addr", mem_addr, md_addr);
            if (md_we) chk("mem_wdata", mem_wdata, md_wdata);
        end
    end

    task automatic go(input bit r0, input bit r1, input bit scr,
                      output int winner, output int lat, output int strobes,
                      output logic [15:0] rd, output logic err,
                      output logic [12:0] s_addr, output logic [15:0] s_wdata,
                      output logic s_wr, output bit stable);
        winner = -1; lat = 0; strobes = 0; rd = '0; err = 1'b0;
        s_addr = '0; s_wdata = '0; s_wr = 1'b0; stable = 1'b1;
        m0_req = r0; m1_req = r1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            if (scr) begin
                m0_addr  = 13'($urandom);
                m0_wdata = 16'($urandom);
            end
            if (mem_read || mem_write) begin
                if (strobes == 0) begin
                    s_addr = mem_addr; s_wdata = mem_wdata; s_wr = mem_write;
                end else if (mem_addr !== s_addr || mem_wdata !== s_wdata) begin
                    stable = 1'b0;
                end
                strobes++;
            end
            if (m0_ack || m1_ack) begin
                winner = m1_ack ? 1 : 0;
                rd  = m1_ack ? m1_rdata : m0_rdata;
                err = m1_ack ? m1_err : m0_err;
                break;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("ack_seen", winner >= 0, 1);
        @(negedge clk);
        chk("ack_one_cycle", {m0_ack, m1_ack}, 0);
    endtask

    task automatic rnd_step();
        if (m0_ack && $urandom_range(0, 3) != 0) m0_req = 1'b0;
        else if (!m0_req) begin
            if ($urandom_range(0, 2) == 0) begin
                m0_req = 1'b1; m0_we = 1'($urandom_range(0, 1));
                m0_addr = 13'($urandom); m0_wdata = 16'($urandom);
            end
        end else begin
            if ($urandom_range(0, 15) == 0) m0_req = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                m0_we = 1'($urandom_range(0, 1));
                m0_addr = 13'($urandom); m0_wdata = 16'($urandom);
            end
        end
        if (m1_ack && $urandom_range(0, 3) != 0) m1_req = 1'b0;
        else if (!m1_req) begin
            if ($urandom_range(0, 2) == 0) begin
                m1_req = 1'b1; m1_we = 1'($urandom_range(0, 1));
                m1_addr = 13'($urandom); m1_wdata = 16'($urandom);
            end
        end else begin
            if ($urandom_range(0, 15) == 0) m1_req = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                m1_we = 1'($urandom_range(0, 1));
                m1_addr = 13'($urandom); m1_wdata = 16'($urandom);
            end
        end
    endtask

    initial begin
        int w, l, s;
        logic [15:0] rd, sw;
        logic er, swr;
        logic [12:0] sa;
        bit st, seen;
        int exp_w [3];
`ifdef ARB_ROUND_ROBIN_EN
        exp_w = '{0, 1, 0};
`else
        exp_w = '{0, 0, 0};
`endif

        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_strobes", {mem_read, mem_write}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // m0 read, done in third strobe cycle
        dir_lat = 2; dir_rdata = 16'hBEEF;
        m0_we = 1'b0; m0_addr = 13'h0010;
        go(1'b1, 1'b0, 1'b0, w, l, s, rd, er, sa, sw, swr, st);
        chk("t1_winner", w, 0);
        chk("t1_strobes", s, 3);
        chk("t1_latency", l, 5);
        chk("t1_rdata", rd, 16'hBEEF);
        chk("t1_err", er, 0);
        chk("t1_addr", sa, 13'h0010);
        chk("t1_is_read", swr, 0);

        // m1 write to the top address
        dir_lat = 1;
        m1_we = 1'b1; m1_addr = 13'h1FFF; m1_wdata = 16'h1234;
        go(1'b0, 1'b1, 1'b0, w, l, s, rd, er, sa, sw, swr, st);
        chk("t2_winner", w, 1);
        chk("t2_strobes", s, 2);
        chk("t2_latency", l, 4);
        chk("t2_addr", sa, 13'h1FFF);
        chk("t2_wdata", sw, 16'h1234);
        chk("t2_is_write", swr, 1);
        chk("t2_owner", owner, 1);

        // simultaneous requests, three rounds
        dir_lat = 0;
        m0_we = 1'b0; m1_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            go(1'b1, 1'b1, 1'b0, w, l, s, rd, er, sa, sw, swr, st);
            chk($sformatf("t3_grant%0d", k), w, exp_w[k]);
        end

        // watchdog abort, then a normal m1 read
        dir_lat = 99;
        m0_we = 1'b0; m0_addr = 13'h0042;
        go(1'b1, 1'b0, 1'b0, w, l, s, rd, er, sa, sw, swr, st);
        chk("t4_winner", w, 0);
        chk("t4_strobes", s, TO);
        chk("t4_latency", l, TO + 2);
        chk("t4_err", er, 1);
        chk("t4_rdata", rd, 16'h0000);
        dir_lat = 0; dir_rdata = 16'h0F0F;
        m1_we = 1'b0; m1_addr = 13'h0100;
        go(1'b0, 1'b1, 1'b0, w, l, s, rd, er, sa, sw, swr, st);
        chk("t4b_winner", w, 1);
        chk("t4b_latency", l, 3);
        chk("t4b_rdata", rd, 16'h0F0F);
        chk("t4b_err", er, 0);

        // m0 write with scrambled inputs during WAIT and a stray rd_done
        dir_lat = 2; dir_stray = 1'b1;
        m0_we = 1'b1; m0_addr = 13'h0AAA; m0_wdata = 16'h5555;
        go(1'b1, 1'b0, 1'b1, w, l, s, rd, er, sa, sw, swr, st);
        chk("t6_winner", w, 0);
        chk("t6_strobes", s, 3);
        chk("t6_addr", sa, 13'h0AAA);
        chk("t6_wdata", sw, 16'h5555);
        chk("t6_stable", st, 1);
        chk("t6_err", er, 0);
        dir_stray = 1'b0;

        // reset in the middle of an m1 write
        dir_lat = 99;
        m1_we = 1'b1; m1_addr = 13'h0123; m1_wdata = 16'hCAFE; m1_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_write) begin seen = 1'b1; break; end
        end
        chk("t5_write_started", seen, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_write_dropped", mem_write, 0);
        chk("t5_busy_dropped", busy, 0);
        chk("t5_owner_cleared", owner, 0);
        chk("t5_no_ack", {m0_ack, m1_ack}, 0);
        m1_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dir_lat = 1; dir_rdata = 16'hA5A5;
        m0_we = 1'b0; m0_addr = 13'h0777;
        go(1'b1, 1'b0, 1'b0, w, l, s, rd, er, sa, sw, swr, st);
        chk("t5b_winner", w, 0);
        chk("t5b_rdata", rd, 16'hA5A5);
        chk("t5b_err", er, 0);

        // randomized traffic; the per-cycle compare process does the checking
        rnd_mem = 1'b1;
        repeat (4000) begin
            @(negedge clk);
            rnd_step();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin seen = 1'b1; break; end
        end
        chk("drain_idle", seen, 1);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
